// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: DATA_BITS 5..9, none/odd/even parity, 1 or 2 stop bits, valid/ready output.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote instead of a single centre sample.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int          BIT_TICKS      = CLK_FREQ / BAUD_RATE;
    localparam int          HALF_BIT_TICKS = BIT_TICKS / 2;
    localparam logic [15:0] C_BIT_RELOAD   = 16'(BIT_TICKS - 1);
    localparam logic [15:0] C_HALF         = 16'(HALF_BIT_TICKS);
    localparam logic [3:0]  C_LAST_BIT     = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_q;
    logic [15:0]          r_tick;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_all_zero;
    logic                 r_stop_bad;
    logic                 r_par_err;
    logic                 r_stop2;

    logic w_sample;
    logic w_tick_zero;
    logic w_accept;
    logic w_fall;
    logic w_par_x;
    logic w_par_err;
    logic w_zero_fin;
    logic w_stop_bad_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_q  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_q  <= r_rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Votes from tick==2 and tick==1 are combined with the live sample at tick==0.
    logic [1:0] r_vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote <= 2'b11;
        end else if (r_tick == 16'd2) begin
            r_vote[1] <= r_rx_s;
        end else if (r_tick == 16'd1) begin
            r_vote[0] <= r_rx_s;
        end
    end

    assign w_sample = (r_vote[1] & r_vote[0]) | (r_vote[1] & r_rx_s) | (r_vote[0] & r_rx_s);
`else
    assign w_sample = r_rx_s;
`endif

    assign w_tick_zero    = (r_tick == 16'd0);
    assign w_accept       = data_valid & data_ready;
    assign w_fall         = r_rx_q & ~r_rx_s;
    assign w_par_x        = (^r_shift) ^ w_sample;
    assign w_par_err      = (PARITY == 1) ? ~w_par_x : w_par_x;
    assign w_zero_fin     = r_all_zero & ~w_sample;
    assign w_stop_bad_fin = r_stop_bad | ~w_sample;
    assign busy           = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_all_zero  <= 1'b0;
            r_stop_bad  <= 1'b0;
            r_par_err   <= 1'b0;
            r_stop2     <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
            if (w_accept) begin
                data_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_tick  <= C_HALF;
                    end
                end
                S_START: begin
                    if (!w_tick_zero) begin
                        r_tick <= r_tick - 16'd1;
                    end else if (!w_sample) begin
                        r_state    <= S_DATA;
                        r_tick     <= C_BIT_RELOAD;
                        r_idx      <= '0;
                        r_all_zero <= 1'b1;
                        r_stop_bad <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_stop2    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_tick_zero) begin
                        r_tick <= r_tick - 16'd1;
                    end else begin
                        // LSB arrives first, so shifting in at the top leaves the word aligned.
                        r_shift    <= {w_sample, r_shift[DATA_BITS-1:1]};
                        r_all_zero <= r_all_zero & ~w_sample;
                        r_tick     <= C_BIT_RELOAD;
                        if (r_idx == C_LAST_BIT) begin
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (!w_tick_zero) begin
                        r_tick <= r_tick - 16'd1;
                    end else begin
                        r_par_err  <= w_par_err;
                        r_all_zero <= r_all_zero & ~w_sample;
                        r_tick     <= C_BIT_RELOAD;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!w_tick_zero) begin
                        r_tick <= r_tick - 16'd1;
                    end else if (STOP_BITS == 2 && !r_stop2) begin
                        r_stop2    <= 1'b1;
                        r_stop_bad <= w_stop_bad_fin;
                        r_all_zero <= w_zero_fin;
                        r_tick     <= C_BIT_RELOAD;
                    end else begin
                        r_state <= S_IDLE;
                        // A handshake in this same cycle frees the slot before the new word lands.
                        if (w_zero_fin) begin
                            break_det <= 1'b1;
                        end else if (w_stop_bad_fin) begin
                            frame_err <= 1'b1;
                        end else if (!data_valid || w_accept) begin
                            data_out   <= r_shift;
                            parity_err <= r_par_err;
                            data_valid <= 1'b1;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7-bit even-parity two-stop instance, directed and random frames.
module tb_uart_rx_cfg;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BT       = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rx;
    logic [1:0] rdy;
    logic [7:0] dout8;
    logic [6:0] dout7;
    logic [1:0] dv, pe, fe, bk, ov, bz;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data_out(dout8), .data_valid(dv[0]),
        .data_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]),
        .overrun_err(ov[0]), .busy(bz[0])
    );

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data_out(dout7), .data_valid(dv[1]),
        .data_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]),
        .overrun_err(ov[1]), .busy(bz[1])
    );

    int n_vec = 0;
    int n_err = 0;
    int n_fe[2] = '{0, 0};
    int n_bk[2] = '{0, 0};
    int n_ov[2] = '{0, 0};
    int n_vc[2] = '{0, 0};
    logic [9:0] got_q0[$];
    logic [9:0] got_q1[$];
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    bit         held[2] = '{1'b0, 1'b0};
    logic [9:0] held_word[2];

    // Event capture half a cycle away from the active edge.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (fe[i]) n_fe[i]++;
                if (bk[i]) n_bk[i]++;
                if (ov[i]) n_ov[i]++;
                if (dv[i]) n_vc[i]++;
            end
            if (dv[0] && rdy[0]) got_q0.push_back({pe[0], 1'b0, dout8});
            if (dv[1] && rdy[1]) got_q1.push_back({pe[1], 2'b00, dout7});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference outcome of one frame: 0 deliver, 1 overrun, 2 framing error, 3 break.
    function automatic int frame_kind(input logic [8:0] d, input bit has_par, input bit pbit,
                                      input bit [1:0] stops, input int nstop, input bit slot_full);
        bit stop_low;
        bit all_zero;
        stop_low = !stops[0] || (nstop == 2 && !stops[1]);
        all_zero = (d == 9'd0) && !(has_par && pbit) &&
                   !stops[0] && (nstop == 1 || !stops[1]);
        if (all_zero) return 3;
        if (stop_low) return 2;
        if (slot_full) return 1;
        return 0;
    endfunction

    task automatic push_exp(input int w, input logic [9:0] v);
        if (w == 0) exp_q0.push_back(v);
        else exp_q1.push_back(v);
    endtask

    task automatic check_q(input int w, input string tag);
        logic [9:0] g, e;
        if (w == 0) begin
            chk({tag, "_nwords"}, got_q0.size(), exp_q0.size());
            while (got_q0.size() > 0 && exp_q0.size() > 0) begin
                g = got_q0.pop_front();
                e = exp_q0.pop_front();
                chk({tag, "_word"}, 32'(g), 32'(e));
            end
            got_q0.delete();
            exp_q0.delete();
        end else begin
            chk({tag, "_nwords"}, got_q1.size(), exp_q1.size());
            while (got_q1.size() > 0 && exp_q1.size() > 0) begin
                g = got_q1.pop_front();
                e = exp_q1.pop_front();
                chk({tag, "_word"}, 32'(g), 32'(e));
            end
            got_q1.delete();
            exp_q1.delete();
        end
    endtask

    task automatic drive(input int w, input logic v, input int cycles);
        rx[w] = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_held(input int w, input string tag);
        logic [8:0] dnow;
        dnow = (w == 0) ? {1'b0, dout8} : {2'b00, dout7};
        chk({tag, "_hold_valid"}, 32'(dv[w]), 32'(1));
        chk({tag, "_hold_data"}, 32'(dnow), 32'(held_word[w][8:0]));
        chk({tag, "_hold_perr"}, 32'(pe[w]), 32'(held_word[w][9]));
    endtask

    // Sends one frame on instance w and checks every status against the reference outcome.
    task automatic do_frame(input int w, input logic [8:0] din, input bit bad_par,
                            input bit [1:0] stops, input bit ready, input string tag);
        int nb, nstop, kind, fe0, bk0, ov0;
        bit has_par, pbit, perr;
        logic [8:0] d;
        nb      = (w == 0) ? 8 : 7;
        nstop   = (w == 0) ? 1 : 2;
        has_par = (w == 1);
        d       = din & ((9'h1 << nb) - 9'h1);
        pbit    = bit'($countones(d) % 2) ^ bad_par;
        perr    = has_par && bad_par;
        @(negedge clk);
        rdy[w] = ready;
        if (ready && held[w]) begin
            push_exp(w, held_word[w]);
            held[w] = 1'b0;
        end
        kind = frame_kind(d, has_par, pbit, stops, nstop, held[w]);
        fe0 = n_fe[w];
        bk0 = n_bk[w];
        ov0 = n_ov[w];
        drive(w, 1'b0, BT);
        for (int i = 0; i < nb; i++) drive(w, d[i], BT);
        if (has_par) drive(w, pbit, BT);
        for (int i = 0; i < nstop; i++) drive(w, stops[i], BT);
        drive(w, 1'b1, 2 * BT);
        if (kind == 0) begin
            if (ready) push_exp(w, {perr, d});
            else begin
                held[w]      = 1'b1;
                held_word[w] = {perr, d};
            end
        end
        chk({tag, "_frame_err"}, n_fe[w] - fe0, (kind == 2) ? 1 : 0);
        chk({tag, "_break"}, n_bk[w] - bk0, (kind == 3) ? 1 : 0);
        chk({tag, "_overrun"}, n_ov[w] - ov0, (kind == 1) ? 1 : 0);
        chk({tag, "_busy"}, 32'(bz[w]), 32'(0));
        check_q(w, tag);
        if (held[w]) check_held(w, tag);
    endtask

    initial begin
        int vc0, fe0, bk0, ov0;
        rx    = 2'b11;
        rdy   = 2'b11;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dut8", {dout8, dv[0], pe[0], fe[0], bk[0], ov[0], bz[0]}, 32'd0);
        chk("rst_dut7", {dout7, dv[1], pe[1], fe[1], bk[1], ov[1], bz[1]}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vc0 = n_vc[0];
        do_frame(0, 9'hA5, 1'b0, 2'b11, 1'b1, "a5");
        chk("a5_valid_cycles", n_vc[0] - vc0, 1);

        do_frame(1, 9'h35, 1'b1, 2'b11, 1'b1, "par35");

        do_frame(0, 9'h3C, 1'b0, 2'b10, 1'b1, "stop3c");
        do_frame(0, 9'h55, 1'b0, 2'b11, 1'b1, "after55");

        // Line held low for 15 bit times.
        fe0 = n_fe[0];
        bk0 = n_bk[0];
        @(negedge clk);
        drive(0, 1'b0, 15 * BT);
        chk("brk_no_retrigger", 32'(bz[0]), 32'(0));
        drive(0, 1'b1, 2 * BT);
        chk("brk_pulses", n_bk[0] - bk0, 1);
        chk("brk_no_frame_err", n_fe[0] - fe0, 0);
        check_q(0, "brk");

        do_frame(0, 9'h11, 1'b0, 2'b11, 1'b0, "ovr11");
        do_frame(0, 9'h22, 1'b0, 2'b11, 1'b0, "ovr22");
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", 32'(dv[0]), 32'(0));
        push_exp(0, held_word[0]);
        held[0] = 1'b0;
        check_q(0, "ovr_drain");

        // Three-cycle glitch on an idle line.
        fe0 = n_fe[0];
        bk0 = n_bk[0];
        ov0 = n_ov[0];
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 2);
        chk("glitch_busy", 32'(bz[0]), 32'(1));
        drive(0, 1'b1, 3 * BT);
        chk("glitch_idle", 32'(bz[0]), 32'(0));
        chk("glitch_events", (n_fe[0] - fe0) + (n_bk[0] - bk0) + (n_ov[0] - ov0), 0);
        check_q(0, "glitch");

        // Reset in the middle of data bit 4 while a word is held.
        do_frame(0, 9'h5A, 1'b0, 2'b11, 1'b0, "held5a");
        drive(0, 1'b0, BT);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, BT);
        drive(0, 1'b0, BT / 2);
        chk("pre_rst_busy", 32'(bz[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {dout8, dv[0], pe[0], fe[0], bk[0], ov[0]}, 32'd0);
        chk("rst_mid_busy", 32'(bz[0]), 32'(0));
        rx = 2'b11;
        held[0] = 1'b0;
        held[1] = 1'b0;
        got_q0.delete();
        got_q1.delete();
        exp_q0.delete();
        exp_q1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_frame(0, 9'h81, 1'b0, 2'b11, 1'b1, "post_rst81");

        for (int n = 0; n < 40; n++) begin
            int w;
            logic [8:0] d;
            bit bp, rd;
            bit [1:0] st;
            w  = int'($urandom % 2);
            d  = 9'($urandom);
            bp = ($urandom % 4) == 0;
            st = {($urandom % 5) != 0, ($urandom % 5) != 0};
            rd = ($urandom % 3) != 0;
            if (($urandom % 10) == 0) begin
                d  = 9'd0;
                bp = 1'b0;
                st = 2'b00;
            end
            do_frame(w, d, bp, st, rd, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver. It supports configurable data width, parity and stop-bit count, and a two-flop input synchroniser. Received words leave through a valid/ready handshake, with per-frame parity, framing, break and overrun status. It sits between the board RX pin and the Speck command/data path.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate. BIT_TICKS = CLK_FREQ/BAUD_RATE (integer divide, at least 8). HALF_BIT_TICKS = BIT_TICKS/2.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  received word.
- data_valid  out  1  high while data_out holds an undelivered word.
- data_ready  in  1  consumer accepts data_out when data_valid && data_ready.
- parity_err  out  1  parity status of the word in data_out; valid while data_valid.
- frame_err  out  1  one-cycle pulse: a stop bit was sampled low (not break).
- break_det  out  1  one-cycle pulse: a whole frame was low.
- overrun_err  out  1  one-cycle pulse: a good frame completed while data_valid was still high.
- busy  out  1  high in any state other than IDLE.

## Operation
- rx passes through a 2-flop synchroniser to give rx_s, plus a third flop rx_q (previous rx_s).
- States and transitions:
  - IDLE: leave for START on a falling edge (rx_q=1, rx_s=0), loading tick=HALF_BIT_TICKS. A constant-low line never retriggers.
  - START: count down. At tick==0, if sample=0 go to DATA with tick=BIT_TICKS-1 and bit index=0. Otherwise the start was false: return to IDLE silently.
  - DATA: at tick==0, shift the sample into bit[index], reload tick=BIT_TICKS-1. After bit DATA_BITS-1, go to PARITY if PARITY≠0, else STOP.
  - PARITY: at tick==0, compute the error. Odd parity: data XOR parity bit must be 1. Even parity: it must be 0. Reload tick and go to STOP.
  - STOP: sample at tick==0. If STOP_BITS=2, sample a second stop bit BIT_TICKS later. Then complete the frame and return to IDLE.
- Frame completion, evaluated in this order:
  1. All data, parity and stop samples 0: pulse break_det. No data delivered.
  2. Any stop sample 0: pulse frame_err. No data delivered.
  3. Otherwise, if data_valid=0: load data_out and parity_err, set data_valid.
  4. Otherwise, if data_valid=1: pulse overrun_err. The new word is dropped and the held word is kept.
- A handshake in the same cycle as completion counts as freeing the slot first. The new word loads and there is no overrun.
- data_valid clears on the accepting cycle unless a new word loads in that same cycle.
- data_ready is ignored while data_valid=0.

## Timing
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, break_det=0, overrun_err=0, busy=0, state=IDLE. Synchroniser flops reset to 1.
- Reset mid-frame aborts the frame immediately and discards the partial word. After reset, a falling edge is needed to start a new frame.
- Input latency: 2 cycles from rx to rx_s.
- Sample point: bit centre, i.e. HALF_BIT_TICKS+k·BIT_TICKS cycles after the detected falling edge of rx_s.
- data_valid and the status pulses assert on the cycle after the final stop sample point.
- Counters are 16 bits, so BIT_TICKS must be less than 65536.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each sample is the majority of rx_s at tick==2, 1 and 0.
  - This applies to start, data, parity and stop bits alike.
  - Single-cycle glitches are rejected.
- UART_RX_MAJORITY_EN undefined:
  - Each sample is rx_s at tick==0 only.
  - The 3-sample voting logic is not generated.

## Test plan
Bench settings: CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BIT_TICKS=10.
- 8N1, send 0xA5, data_ready=1 -> data_valid for 1 cycle, data_out=0xA5, parity_err=0, no error pulses.
- DATA_BITS=7, PARITY=2, send 0x35 with parity bit 1 (wrong) -> data_valid, data_out=0x35, parity_err=1.
- 8N1, send 0x3C with stop bit 0 -> frame_err pulse, data_valid stays 0. Then a falling edge followed by 0x55 -> data_out=0x55.
- Hold rx low for 15 bit times -> exactly one break_det pulse, no frame_err, no retrigger until rx goes high and falls again.
- data_ready=0, send 0x11 then 0x22 -> data_out=0x11 held, one overrun_err pulse at the end of the second frame. Raise data_ready -> data_valid drops the next cycle.
- 3-cycle low glitch on an idle line -> returns to IDLE with no outputs. Assert rst_n=0 mid-data-bit 4 -> all outputs 0 and busy=0 immediately, then the next frame 0x81 is received correctly.
